// File: rtl/bram_sync_dp_be_if.sv
// One memory port of bram_sync_dp_be: access request going in, tagged read data coming out.
// The master drives the request; the RAM uses the slave view.
interface bram_sync_dp_be_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int BYTE_WIDTH = 8
);
    localparam int NB = DATA_WIDTH / BYTE_WIDTH;

    logic                  en;
    logic [NB-1:0]         we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] dout;
    logic                  valid;

    modport master (output en, we, addr, din, input dout, valid);
    modport slave  (input en, we, addr, din, output dout, valid);
endinterface

// File: rtl/bram_sync_dp_be.sv
// Single-clock true dual-port RAM with byte write enables, selectable read-during-write
// behaviour, optional output register, valid-tagged read data and a same-address collision flag.
module bram_sync_dp_be #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int BYTE_WIDTH = 8,
    parameter int WRITE_MODE = 0,
    parameter int OUT_REG    = 0
) (
    input  logic                clk,
    input  logic                rst,
    bram_sync_dp_be_if.slave    a_port,
    bram_sync_dp_be_if.slave    b_port,
    output logic                collision
);
    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
        $error("bram_sync_dp_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (WRITE_MODE < 0 || WRITE_MODE > 2) begin : g_bad_mode
        $error("bram_sync_dp_be: WRITE_MODE must be 0, 1 or 2");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DATA_WIDTH-1:0] a_old, b_old;
    logic [NB-1:0]         a_lane_we, b_lane_we;
    logic                  same_addr;

    logic [DATA_WIDTH-1:0] a_data_p1_d, a_data_p1_q, b_data_p1_d, b_data_p1_q;
    logic                  a_vld_p1_d, a_vld_p1_q, b_vld_p1_d, b_vld_p1_q;
    logic [DATA_WIDTH-1:0] a_data_p2_d, a_data_p2_q, b_data_p2_d, b_data_p2_q;
    logic                  a_vld_p2_d, a_vld_p2_q, b_vld_p2_d, b_vld_p2_q;
    logic                  collision_d, collision_q;

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [NB-1:0]         we
    );
        logic [DATA_WIDTH-1:0] r;
        r = old_w;
        for (int i = 0; i < NB; i++) begin
            if (we[i]) r[i*BYTE_WIDTH +: BYTE_WIDTH] = new_w[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
        return r;
    endfunction

    // Returns {valid, data} for the first read stage; data holds when nothing is returned.
    function automatic logic [DATA_WIDTH:0] rd_update(
        input logic                  en,
        input logic [NB-1:0]         we,
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] din,
        input logic [DATA_WIDTH-1:0] held
    );
        logic [DATA_WIDTH:0] r;
        r = {1'b0, held};
        if (en) begin
            if (WRITE_MODE == 1) begin
                r = {1'b1, merge_bytes(old_w, din, we)};
            end else if (WRITE_MODE == 0 || we == '0) begin
                r = {1'b1, old_w};
            end
        end
        return r;
    endfunction

    always_comb begin
        a_old     = mem[a_port.addr];
        b_old     = mem[b_port.addr];
        same_addr = (a_port.addr == b_port.addr);
        a_lane_we = (a_port.en && !rst) ? a_port.we : '0;
        b_lane_we = (b_port.en && !rst) ? b_port.we : '0;
        // Port A owns any lane it writes when both ports hit the same word.
        if (same_addr) b_lane_we = b_lane_we & ~a_lane_we;

        collision_d = a_port.en & b_port.en & same_addr & ((|a_port.we) | (|b_port.we));

        {a_vld_p1_d, a_data_p1_d} = rd_update(a_port.en, a_port.we, a_old, a_port.din, a_data_p1_q);
        {b_vld_p1_d, b_data_p1_d} = rd_update(b_port.en, b_port.we, b_old, b_port.din, b_data_p1_q);

        a_vld_p2_d  = a_vld_p1_q;
        a_data_p2_d = a_vld_p1_q ? a_data_p1_q : a_data_p2_q;
        b_vld_p2_d  = b_vld_p1_q;
        b_data_p2_d = b_vld_p1_q ? b_data_p1_q : b_data_p2_q;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (a_lane_we[i]) mem[a_port.addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= a_port.din[i*BYTE_WIDTH +: BYTE_WIDTH];
            if (b_lane_we[i]) mem[b_port.addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= b_port.din[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end

    // Stage 1: read data / valid straight from the array
    // Stage 2: optional output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_data_p1_q <= '0;
            a_vld_p1_q  <= 1'b0;
            b_data_p1_q <= '0;
            b_vld_p1_q  <= 1'b0;
            a_data_p2_q <= '0;
            a_vld_p2_q  <= 1'b0;
            b_data_p2_q <= '0;
            b_vld_p2_q  <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            a_data_p1_q <= a_data_p1_d;
            a_vld_p1_q  <= a_vld_p1_d;
            b_data_p1_q <= b_data_p1_d;
            b_vld_p1_q  <= b_vld_p1_d;
            a_data_p2_q <= a_data_p2_d;
            a_vld_p2_q  <= a_vld_p2_d;
            b_data_p2_q <= b_data_p2_d;
            b_vld_p2_q  <= b_vld_p2_d;
            collision_q <= collision_d;
        end
    end

    assign a_port.dout  = (OUT_REG != 0) ? a_data_p2_q : a_data_p1_q;
    assign a_port.valid = (OUT_REG != 0) ? a_vld_p2_q  : a_vld_p1_q;
    assign b_port.dout  = (OUT_REG != 0) ? b_data_p2_q : b_data_p1_q;
    assign b_port.valid = (OUT_REG != 0) ? b_vld_p2_q  : b_vld_p1_q;
    assign collision    = collision_q;
endmodule
